// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table scanner.
//   state_t : scanner FSM states
//   tw_of   : truth-table width for a given number of function inputs
//   cnt_w   : settle-counter width for a given hold length (minimum 1 bit)
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int tw_of(input int n_in);
    return 1 << n_in;
  endfunction

  // The counter only ever holds SETTLE_CYCLES-1 down to 0.
  function automatic int cnt_w(input int settle);
    return (settle <= 2) ? 1 : $clog2(settle);
  endfunction

endpackage

// File: rtl/tt_first_diff.sv
// Lowest-set-bit priority encoder over (captured ^ expected).
//   captured : sampled truth table
//   expected : reference truth table
//   idx      : lowest index where the two differ (0 when identical)
//   any_set  : 1 when at least one bit differs
module tt_first_diff
  import tt_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int TW   = tw_of(N_IN)
) (
  input  logic [TW-1:0]   captured,
  input  logic [TW-1:0]   expected,
  output logic [N_IN-1:0] idx,
  output logic            any_set
);

  logic [TW-1:0] diff;

  assign diff = captured ^ expected;

  always_comb begin
    idx     = '0;
    any_set = 1'b0;
    for (int unsigned i = 0; i < TW; i++) begin
      if (diff[i] && !any_set) begin
        idx     = N_IN'(i);
        any_set = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tt_scanner.sv
// Sequential truth-table scanner: walks abc through 0..TW-1, holds each
// pattern SETTLE_CYCLES cycles, samples y_in at the end of each window,
// and compares the captured table with the expected table latched at start.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : scan request (accepted in IDLE only)
//   expected   : expected table, bit k = y for pattern k
//   y_in       : output of the function under test
//   abc        : pattern driven to the function under test (MSB = a)
//   busy       : high while patterns are being driven
//   done       : one-cycle result strobe
//   pass       : captured == expected
//   fail_idx   : lowest mismatching index (0 on pass)
//   table_out  : captured truth table
module tt_scanner
  import tt_pkg::*;
#(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [tw_of(N_IN)-1:0]  expected,
  input  logic                    y_in,
  output logic [N_IN-1:0]         abc,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [N_IN-1:0]         fail_idx,
  output logic [tw_of(N_IN)-1:0]  table_out
);

  localparam int TW = tw_of(N_IN);
  localparam int CW = cnt_w(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("tt_scanner: SETTLE_CYCLES must be >= 1");
  end

  state_t          state;
  logic [TW-1:0]   exp_q;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   table_nxt;
  logic [N_IN-1:0] diff_idx;
  logic            diff_any;

  // abc doubles as the pattern index k: it is 0 in IDLE and DONE anyway.
  // The final verdict must include the bit sampled on the same edge, so the
  // comparator looks at the table with the current y_in merged in.
  always_comb begin
    table_nxt      = table_out;
    table_nxt[abc] = y_in;
  end

  tt_first_diff #(
    .N_IN (N_IN),
    .TW   (TW)
  ) u_first_diff (
    .captured (table_nxt),
    .expected (exp_q),
    .idx      (diff_idx),
    .any_set  (diff_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      exp_q     <= '0;
      cnt       <= '0;
      abc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_idx  <= '0;
      table_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= DRIVE;
            exp_q     <= expected;
            abc       <= '0;
            cnt       <= CNT_LOAD;
            table_out <= '0;
            pass      <= 1'b0;
            fail_idx  <= '0;
            busy      <= 1'b1;
          end
        end
        DRIVE: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            table_out <= table_nxt;
            if (abc == '1) begin
              state    <= DONE;
              abc      <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
              pass     <= !diff_any;
              fail_idx <= diff_idx;
            end else begin
              abc <= abc + N_IN'(1);
              cnt <= CNT_LOAD;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_scanner.sv
// Directed self-checking bench for tt_scanner: u_s2 (SETTLE_CYCLES = 2)
// and u_s3 (SETTLE_CYCLES = 3), each fed by a 4:1 mux model.
module tb_tt_scanner;

  logic       clk;
  logic       rst_n;

  logic       start1, start2;
  logic [7:0] exp1, exp2;
  logic       y1, y2;
  logic [2:0] abc1, abc2;
  logic       busy1, busy2, done1, done2, pass1, pass2;
  logic [2:0] fidx1, fidx2;
  logic [7:0] tab1, tab2;
  logic       inv5;

  int nchecks = 0;
  int npass   = 0;

  // 4:1 mux, select {a,b}, data inputs {1, 0, c, c} -> table 8'hCA
  function automatic logic mux_model(input logic [2:0] p);
    case (p[2:1])
      2'b00, 2'b01: return p[0];
      2'b10:        return 1'b0;
      default:      return 1'b1;
    endcase
  endfunction

  assign y1 = mux_model(abc1) ^ (inv5 && abc1 == 3'd5);
  assign y2 = mux_model(abc2);

  tt_scanner #(.N_IN(3), .SETTLE_CYCLES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .y_in(y1),
    .abc(abc1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_idx(fidx1), .table_out(tab1)
  );

  tt_scanner #(.N_IN(3), .SETTLE_CYCLES(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start2), .expected(exp2), .y_in(y2),
    .abc(abc2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_idx(fidx2), .table_out(tab2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present start/expected on a falling edge; the next rising edge is E0.
  task automatic launch1(input logic [7:0] e);
    @(negedge clk);
    exp1   = e;
    start1 = 1'b1;
  endtask

  // Counts falling edges after E0 until done1 is seen; -1 on timeout.
  task automatic wait_done1(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (done1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
    exp1 = 8'h00; exp2 = 8'h00; inv5 = 1'b0;
    repeat (2) @(negedge clk);
    nchecks++;
    if ({abc1, busy1, done1, pass1, fidx1, tab1} !== 16'h0) begin
      $display("FAIL reset_s2: got %h want 0000", {abc1, busy1, done1, pass1, fidx1, tab1});
    end else npass++;
    nchecks++;
    if ({abc2, busy2, done2, pass2, fidx2, tab2} !== 16'h0) begin
      $display("FAIL reset_s3: got %h want 0000", {abc2, busy2, done2, pass2, fidx2, tab2});
    end else npass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_golden;
    int cyc;
    launch1(8'hCA);
    wait_done1(cyc);
    nchecks++;
    if (cyc !== 17) $display("FAIL golden_latency: got %0d want 17", cyc);
    else npass++;
    nchecks++;
    if ({pass1, fidx1, tab1} !== {1'b1, 3'd0, 8'hCA})
      $display("FAIL golden_result: got pass=%b idx=%0d tab=%h want pass=1 idx=0 tab=ca", pass1, fidx1, tab1);
    else npass++;
    @(negedge clk);
    nchecks++;
    if ({done1, busy1, pass1, tab1} !== {1'b0, 1'b0, 1'b1, 8'hCA})
      $display("FAIL golden_hold: got done=%b busy=%b pass=%b tab=%h want 0 0 1 ca", done1, busy1, pass1, tab1);
    else npass++;
  endtask

  task automatic test_mismatch;
    int cyc;
    inv5 = 1'b1;
    launch1(8'hCA);
    wait_done1(cyc);
    inv5 = 1'b0;
    nchecks++;
    if ({pass1, fidx1, tab1} !== {1'b0, 3'd5, 8'hEA})
      $display("FAIL mismatch_result: got pass=%b idx=%0d tab=%h want pass=0 idx=5 tab=ea", pass1, fidx1, tab1);
    else npass++;
    @(negedge clk);
    nchecks++;
    if (done1 !== 1'b0) $display("FAIL mismatch_single_done: got %b want 0", done1);
    else npass++;
  endtask

  task automatic test_timing_s3;
    int busy_cnt = 0, done_cnt = 0, done_at = -1, abc_err = 0;
    @(negedge clk);
    exp2   = 8'hCA;
    start2 = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (busy2) busy_cnt++;
      if (done2) begin
        done_cnt++;
        done_at = i;
      end
      if (i <= 24 && abc2 !== 3'((i - 1) / 3)) abc_err++;
      if (i > 24 && abc2 !== 3'd0) abc_err++;
    end
    nchecks++;
    if (busy_cnt !== 24) $display("FAIL s3_busy_cycles: got %0d want 24", busy_cnt);
    else npass++;
    nchecks++;
    if (done_cnt !== 1 || done_at !== 25)
      $display("FAIL s3_done: got count=%0d at=%0d want count=1 at=25", done_cnt, done_at);
    else npass++;
    nchecks++;
    if (abc_err !== 0) $display("FAIL s3_abc_steps: got %0d bad cycles want 0", abc_err);
    else npass++;
    nchecks++;
    if ({pass2, tab2} !== {1'b1, 8'hCA}) $display("FAIL s3_result: got pass=%b tab=%h want 1 ca", pass2, tab2);
    else npass++;
  endtask

  task automatic test_ignored_start;
    int cyc = -1, busy_after = 0;
    launch1(8'hCA);
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      start1 = (abc1 == 3'd4) && busy1 && i < 12;
      if (done1) begin
        cyc = i;
        break;
      end
    end
    start1 = 1'b1;          // pulse during the done cycle
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (busy1 || abc1 != 3'd0) busy_after++;
    end
    nchecks++;
    if (cyc !== 17) $display("FAIL ignore_latency: got %0d want 17", cyc);
    else npass++;
    nchecks++;
    if ({pass1, tab1} !== {1'b1, 8'hCA}) $display("FAIL ignore_result: got pass=%b tab=%h want 1 ca", pass1, tab1);
    else npass++;
    nchecks++;
    if (busy_after !== 0) $display("FAIL ignore_no_rescan: got %0d busy cycles want 0", busy_after);
    else npass++;
  endtask

  task automatic test_reset_mid_scan;
    int cyc, done_seen = 0;
    bit reached = 0;
    launch1(8'hCA);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (abc1 == 3'd3) begin
        reached = 1;
        break;
      end
    end
    nchecks++;
    if (!reached || tab1 !== 8'h02) $display("FAIL midscan_reach: got reached=%b tab=%h want 1 02", reached, tab1);
    else npass++;
    #2 rst_n = 1'b0;
    #1;
    nchecks++;
    if ({abc1, busy1, done1, pass1, fidx1, tab1} !== 16'h0)
      $display("FAIL midscan_async_clear: got %h want 0000", {abc1, busy1, done1, pass1, fidx1, tab1});
    else npass++;
    repeat (3) begin
      @(negedge clk);
      if (done1) done_seen++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done1 || busy1) done_seen++;
    end
    nchecks++;
    if (done_seen !== 0) $display("FAIL midscan_no_done: got %0d want 0", done_seen);
    else npass++;
    launch1(8'hCA);
    wait_done1(cyc);
    nchecks++;
    if (cyc !== 17 || {pass1, fidx1, tab1} !== {1'b1, 3'd0, 8'hCA})
      $display("FAIL midscan_restart: got cyc=%0d pass=%b idx=%0d tab=%h want 17 1 0 ca", cyc, pass1, fidx1, tab1);
    else npass++;
  endtask

  task automatic test_expected_latch;
    int cyc;
    launch1(8'hCA);
    @(negedge clk);
    start1 = 1'b0;
    exp1   = 8'h00;
    wait_done1(cyc);
    nchecks++;
    if (cyc !== 16 || {pass1, tab1} !== {1'b1, 8'hCA})
      $display("FAIL expected_latch: got cyc=%0d pass=%b tab=%h want 16 1 ca", cyc, pass1, tab1);
    else npass++;
  endtask

  task automatic test_back_to_back;
    int cyc;
    exp1 = 8'hCA;
    inv5 = 1'b1;
    launch1(8'hCA);
    wait_done1(cyc);
    inv5 = 1'b0;
    launch1(8'hCA);         // falling edge in the IDLE cycle after done
    wait_done1(cyc);
    nchecks++;
    if (cyc !== 17 || {pass1, fidx1, tab1} !== {1'b1, 3'd0, 8'hCA})
      $display("FAIL back_to_back: got cyc=%0d pass=%b idx=%0d tab=%h want 17 1 0 ca", cyc, pass1, fidx1, tab1);
    else npass++;
  endtask

  initial begin
    test_reset;
    test_golden;
    test_mismatch;
    test_timing_s3;
    test_ignored_start;
    test_reset_mid_scan;
    test_expected_latch;
    test_back_to_back;
    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end

endmodule

// File: doc/tt_scanner.md
# tt_scanner

Sequential truth-table scanner that sits directly upstream of a small combinational function block such as the POS 4:1 mux.
- On `start` it drives every input pattern {a,b,c} = 0..2^N_IN-1 in ascending order.
- It holds each pattern for a settle window, samples the block's output `y`, and assembles the sampled bits into a truth table.
- It compares that table against an expected table latched at start and reports pass/fail plus the first failing index.
- Replaces hand-written stimulus sequences with a synthesizable self-check stage.

## Interface
Parameters:
- `N_IN`, 3, number of function inputs; table width is `TW = 2**N_IN`.
- `SETTLE_CYCLES`, 2, cycles each pattern is held before `y` is sampled; must be >= 1 (elaboration-time check).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request a scan; accepted only in IDLE.
- `expected`  in  TW  expected truth table; bit k = expected `y` for pattern k; latched on accepted start.
- `y_in`  in  1  output of the function under test.
- `abc`  out  N_IN  pattern driven to the function under test; MSB = a.
- `busy`  out  1  high from the cycle after start is accepted through the last sample.
- `done`  out  1  single-cycle pulse; `pass`, `fail_idx` and `table_out` are valid in this cycle.
- `pass`  out  1  1 when the captured table equals the expected table; held until the next accepted start.
- `fail_idx`  out  N_IN  lowest index where the captured and expected bits differ; 0 when `pass` = 1.
- `table_out`  out  TW  captured truth table; held until the next accepted start.

## Operation
- States:
  - IDLE: `abc` = 0, `busy` = 0.
  - DRIVE: one pattern is being driven and settled.
  - DONE: lasts exactly one cycle.
- IDLE -> DRIVE on `start` = 1. At that edge:
  - latch `expected`;
  - set index k = 0;
  - load settle counter `cnt` = SETTLE_CYCLES-1;
  - clear `table_out`, `pass` and `fail_idx`.
- DRIVE: `abc` = k.
  - Each edge with `cnt` != 0: decrement `cnt`.
  - Edge with `cnt` == 0: `table_out[k]` <= `y_in`.
  - If k == TW-1: go to DONE. Otherwise increment k and reload `cnt`.
- At the DRIVE -> DONE edge, compute `pass` and `fail_idx` from the complete table, including the bit just sampled.
- DONE: `done` = 1, `abc` = 0. Next state is IDLE unconditionally.
- `start` is ignored in DRIVE and DONE; no queueing.
- `expected` changes after acceptance have no effect on the running scan.
- `y_in` is sampled only at the final edge of each hold window; glitches earlier in the window are ignored.
- Reset, asserted at any time including mid-scan:
  - state = IDLE;
  - `abc`, `busy`, `done`, `pass`, `fail_idx`, `table_out`, the latched expected table, k and `cnt` all = 0.
  - No `done` pulse is produced for an aborted scan.
- k is N_IN bits wide and never wraps; the terminal test is k == TW-1.

## Timing
- Call the edge that accepts `start` edge E0.
- Pattern k is driven from edge E0 + k·S through edge E0 + (k+1)·S, where S = SETTLE_CYCLES.
- `y_in` for pattern k is sampled at edge E0 + (k+1)·S.
- `busy` is high for TW·S cycles.
- `done` is high in the single cycle following edge E0 + TW·S.
- With N_IN = 3 and S = 2: 16 busy cycles, then `done`.
- Earliest next accepted `start` is the first edge after the `done` cycle (back-to-back scans with one IDLE cycle between them).
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `tt_pkg` holds:
  - the state enum (IDLE, DRIVE, DONE);
  - the TW derivation function;
  - the settle-counter width derivation ($clog2 of SETTLE_CYCLES, minimum 1).
- Sub-module `tt_first_diff`: purely combinational lowest-set-bit priority encoder over `table ^ expected`.
  - Outputs the index and an any-set flag.
  - `pass` = !any-set.

## Test plan
- Golden match: N_IN = 3, S = 2, `expected` = 8'hCA, `y_in` driven by a 4:1 mux model (a,b select, c data) -> `done` at E0 + 17 cycles, `pass` = 1, `fail_idx` = 0, `table_out` = 8'hCA.
- Single mismatch: same setup with the model output inverted when `abc` = 5 -> `pass` = 0, `fail_idx` = 5, `table_out` = 8'hEA.
- Timing: S = 3 -> `abc` steps 0..7 every 3 cycles, `busy` high for exactly 24 cycles, exactly one `done` pulse.
- Ignored start: pulse `start` while `abc` = 4 and again in the `done` cycle -> scan unaffected, no second scan begins.
- Reset mid-scan: drop `rst_n` while `abc` = 3 -> all outputs 0 asynchronously, no `done`; a restart after release runs a full, correct scan.
- Expected latch: change `expected` to 8'h00 one cycle after start -> result still compared against the original 8'hCA, `pass` = 1.
